axi_crossbar_rr_arbiter: RTL and testbench

Parametrised, lock-holding arbiter for the AXI crossbar address channels. It picks one of AXI_REQUEST_NUM requesters, either by true round-robin or by fixed priority. The grant is held until the owning transfer signals completion, or until an optional hold timeout fires. It sits between the master-side request decode and the slave-side channel mux, and drives the mux select directly.

---
 rtl/axi_crossbar_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_axi_crossbar_rr_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_crossbar_rr_arbiter.sv
// Lock-holding requester arbiter for the AXI crossbar address channels.
// Round-robin or fixed-priority selection; grant held until done_i or hold timeout.
module axi_crossbar_rr_arbiter #(
  parameter int unsigned AXI_REQUEST_NUM = 4,
  parameter int unsigned ARB_MODE        = 0,
  parameter int unsigned MAX_HOLD        = 0,
  localparam int unsigned IDX_W          = (AXI_REQUEST_NUM > 1) ? $clog2(AXI_REQUEST_NUM) : 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [AXI_REQUEST_NUM-1:0] requests_i,
  input  logic                       done_i,
  output logic [AXI_REQUEST_NUM-1:0] grant_o,
  output logic                       grant_valid_o,
  output logic [IDX_W-1:0]           grant_idx_o,
  output logic                       timeout_o
);

  localparam int unsigned N     = AXI_REQUEST_NUM;
  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [N-1:0]     ptr_q, ptr_d;
  logic [N-1:0]     ptr_rot;
  logic [N-1:0]     winner;
  logic [2*N-1:0]   dbl;
  logic [2*N-1:0]   dbl_pick;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_hit;
  logic             rel;

  // Pointer moves one past the current grantee, MSB wrapping to bit 0.
  for (genvar g = 0; g < N; g++) begin : g_rot
    assign ptr_rot[(g + 1) % N] = grant_q[g];
  end

  assign hold_hit = (MAX_HOLD != 0) && (state_q == ST_GRANT) && !done_i &&
                    (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign rel      = (state_q == ST_GRANT) && (done_i || hold_hit);

  always_comb begin
    ptr_d = ptr_q;
    if (rel) begin
      ptr_d = (ARB_MODE == 0) ? ptr_rot : N'(1);
    end
  end

  // Lowest request at or above the (updated) pointer, wrapping around.
  always_comb begin
    dbl      = {requests_i, requests_i};
    dbl_pick = dbl & ~(dbl - {{N{1'b0}}, ptr_d});
    winner   = dbl_pick[N-1:0] | dbl_pick[2*N-1:N];
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|requests_i) begin
          state_d = ST_GRANT;
          grant_d = winner;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          timeout_d = hold_hit;
          cnt_d     = '0;
          if (|requests_i) begin
            grant_d = winner;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end else if (MAX_HOLD != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Index and valid derived from the next grant so all three stay in lockstep.
  always_comb begin
    idx_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_d[i]) begin
        idx_d = idx_d | IDX_W'(i);
      end
    end
    valid_d = |grant_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= N'(1);
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = valid_q;
  assign grant_idx_o   = idx_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_axi_crossbar_rr_arbiter.sv
// Bench for axi_crossbar_rr_arbiter: four configurations against an index-based reference model.
module tb_axi_crossbar_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req  [4];
  logic       done [4];

  logic [3:0] g0, g1, g2;
  logic [0:0] g3;
  logic [1:0] i0, i1, i2;
  logic [0:0] i3;
  logic       v0, v1, v2, v3;
  logic       t0, t1, t2, t3;

  int compares = 0;
  int fails    = 0;

  // Reference model state: grantee index (-1 = none), pointer index, hold count.
  int m_grant [4];
  int m_ptr   [4];
  int m_cnt   [4];
  bit m_to    [4];
  int cfg_n    [4] = '{4, 4, 4, 1};
  int cfg_mode [4] = '{0, 0, 1, 0};
  int cfg_hold [4] = '{0, 8, 0, 0};

  axi_crossbar_rr_arbiter #(.AXI_REQUEST_NUM(4), .ARB_MODE(0), .MAX_HOLD(0)) u0 (
    .ACLK(clk), .ARESETN(rst_n), .requests_i(req[0]), .done_i(done[0]),
    .grant_o(g0), .grant_valid_o(v0), .grant_idx_o(i0), .timeout_o(t0));
  axi_crossbar_rr_arbiter #(.AXI_REQUEST_NUM(4), .ARB_MODE(0), .MAX_HOLD(8)) u1 (
    .ACLK(clk), .ARESETN(rst_n), .requests_i(req[1]), .done_i(done[1]),
    .grant_o(g1), .grant_valid_o(v1), .grant_idx_o(i1), .timeout_o(t1));
  axi_crossbar_rr_arbiter #(.AXI_REQUEST_NUM(4), .ARB_MODE(1), .MAX_HOLD(0)) u2 (
    .ACLK(clk), .ARESETN(rst_n), .requests_i(req[2]), .done_i(done[2]),
    .grant_o(g2), .grant_valid_o(v2), .grant_idx_o(i2), .timeout_o(t2));
  axi_crossbar_rr_arbiter #(.AXI_REQUEST_NUM(1), .ARB_MODE(0), .MAX_HOLD(0)) u3 (
    .ACLK(clk), .ARESETN(rst_n), .requests_i(req[3][0:0]), .done_i(done[3]),
    .grant_o(g3), .grant_valid_o(v3), .grant_idx_o(i3), .timeout_o(t3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs(int k);
    case (k)
      0: return {g0, v0, i0, t0};
      1: return {g1, v1, i1, t1};
      2: return {g2, v2, i2, t2};
      default: return {3'b000, g3, v3, 1'b0, i3, t3};
    endcase
  endfunction

  function automatic logic [7:0] exp_out(int k);
    logic [3:0] g;
    logic [1:0] idx;
    g   = (m_grant[k] < 0) ? 4'b0 : 4'(1 << m_grant[k]);
    idx = (m_grant[k] < 0) ? 2'd0 : 2'(m_grant[k]);
    return {g, (m_grant[k] >= 0), idx, m_to[k]};
  endfunction

  function automatic int pick(int k, logic [3:0] r);
    for (int off = 0; off < cfg_n[k]; off++) begin
      int idx;
      idx = (m_ptr[k] + off) % cfg_n[k];
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_grant[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_to[k] = 1'b0;
    end
  endfunction

  // One clock of the arbitration rules, applied to the inputs about to be sampled.
  function automatic void model_step(int k);
    logic [3:0] r;
    bit d, hit;
    r = req[k] & 4'((1 << cfg_n[k]) - 1);
    d = done[k];
    m_to[k] = 1'b0;
    if (m_grant[k] < 0) begin
      m_grant[k] = pick(k, r);
      m_cnt[k]   = 0;
    end else begin
      hit = (cfg_hold[k] > 0) && !d && (m_cnt[k] == cfg_hold[k] - 1);
      if (d || hit) begin
        m_ptr[k]   = (cfg_mode[k] == 0) ? (m_grant[k] + 1) % cfg_n[k] : 0;
        m_to[k]    = hit;
        m_grant[k] = pick(k, r);
        m_cnt[k]   = 0;
      end else begin
        m_cnt[k]++;
      end
    end
  endfunction

  task automatic tick(int k);
    model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req[k] = 4'b0; done[k] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req[k] = 4'hF; done[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      compares++;
      if (obs(k) !== 8'h00) begin
        fails++;
        $display("FAIL reset dut%0d: got %b want %b", k, obs(k), 8'h00);
      end
    end
    do_reset();
  endtask

  task automatic test_rr_rotation();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req[0] = 4'hF; done[0] = 1'b0;
    tick(0);
    compares++;
    if (g0 !== seq[0]) begin
      fails++; $display("FAIL rr_first: got %b want %b", g0, seq[0]);
    end
    for (int j = 1; j < 5; j++) begin
      done[0] = 1'b0;
      tick(0);
      compares++;
      if (obs(0) !== exp_out(0) || g0 !== seq[j-1]) begin
        fails++; $display("FAIL rr_hold%0d: got %b want %b/%b", j, obs(0), exp_out(0), seq[j-1]);
      end
      done[0] = 1'b1;
      tick(0);
      compares++;
      if (obs(0) !== exp_out(0) || g0 !== seq[j]) begin
        fails++; $display("FAIL rr_next%0d: got %b want %b/%b", j, obs(0), exp_out(0), seq[j]);
      end
    end
    done[0] = 1'b0;
  endtask

  task automatic test_drop_request();
    do_reset();
    req[0] = 4'b0101;
    tick(0);
    compares++;
    if (g0 !== 4'b0001) begin
      fails++; $display("FAIL drop_first: got %b want 0001", g0);
    end
    req[0] = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      tick(0);
      compares++;
      if (g0 !== 4'b0001 || obs(0) !== exp_out(0)) begin
        fails++; $display("FAIL drop_hold%0d: got %b want %b", c, obs(0), exp_out(0));
      end
    end
    done[0] = 1'b1;
    tick(0);
    compares++;
    if ({g0, v0, i0} !== {4'b0100, 1'b1, 2'd2}) begin
      fails++; $display("FAIL drop_switch: got %b want 0100_1_10", {g0, v0, i0});
    end
    done[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req[0] = 4'b0010;
    tick(0);
    for (int c = 0; c < 9; c++) begin
      done[0] = (c % 3 == 2);
      tick(0);
      compares++;
      if ({g0, v0, i0} !== {4'b0010, 1'b1, 2'd1} || obs(0) !== exp_out(0)) begin
        fails++; $display("FAIL b2b%0d: got %b want %b", c, obs(0), exp_out(0));
      end
    end
    req[0] = 4'b0; done[0] = 1'b1;
    tick(0);
    compares++;
    if ({g0, v0} !== 5'b0 || obs(0) !== exp_out(0)) begin
      fails++; $display("FAIL b2b_release: got %b want %b", obs(0), exp_out(0));
    end
    done[0] = 1'b0;
  endtask

  task automatic test_hold_timeout();
    do_reset();
    req[1] = 4'b0011;
    tick(1);
    for (int c = 0; c < 7; c++) begin
      tick(1);
      compares++;
      if ({g1, t1} !== {4'b0001, 1'b0} || obs(1) !== exp_out(1)) begin
        fails++; $display("FAIL hold%0d: got %b want %b", c, obs(1), exp_out(1));
      end
    end
    tick(1);
    compares++;
    if ({g1, t1} !== {4'b0010, 1'b1} || obs(1) !== exp_out(1)) begin
      fails++; $display("FAIL timeout_fire: got %b want %b", obs(1), exp_out(1));
    end
    for (int c = 0; c < 7; c++) begin
      tick(1);
      compares++;
      if ({g1, t1} !== {4'b0010, 1'b0} || obs(1) !== exp_out(1)) begin
        fails++; $display("FAIL hold2_%0d: got %b want %b", c, obs(1), exp_out(1));
      end
    end
    done[1] = 1'b1;
    tick(1);
    compares++;
    if ({g1, t1} !== {4'b0001, 1'b0} || obs(1) !== exp_out(1)) begin
      fails++; $display("FAIL timeout_with_done: got %b want %b", obs(1), exp_out(1));
    end
    done[1] = 1'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req[2] = 4'b1110;
    tick(2);
    for (int c = 0; c < 8; c++) begin
      if (c == 4) req[2] = 4'b1111;
      done[2] = (c != 0);
      tick(2);
      compares++;
      if (g2 !== ((c < 4) ? 4'b0010 : 4'b0001) || obs(2) !== exp_out(2)) begin
        fails++; $display("FAIL prio%0d: got %b want %b", c, obs(2), exp_out(2));
      end
    end
    done[2] = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req[0] = 4'hF;
    tick(0);
    done[0] = 1'b1;
    tick(0);
    tick(0);
    compares++;
    if (g0 !== 4'b0100) begin
      fails++; $display("FAIL pre_reset: got %b want 0100", g0);
    end
    done[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compares++;
    if (obs(0) !== 8'h00) begin
      fails++; $display("FAIL async_reset: got %b want 00000000", obs(0));
    end
    model_reset();
    #2 rst_n = 1'b1;
    tick(0);
    compares++;
    if ({g0, i0} !== {4'b0001, 2'd0} || obs(0) !== exp_out(0)) begin
      fails++; $display("FAIL restart: got %b want %b", obs(0), exp_out(0));
    end
  endtask

  task automatic test_single();
    do_reset();
    req[3] = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      done[3] = (c != 0);
      tick(3);
      compares++;
      if ({g3, v3, i3} !== 3'b110 || obs(3) !== exp_out(3)) begin
        fails++; $display("FAIL single%0d: got %b want %b", c, obs(3), exp_out(3));
      end
    end
    req[3] = 4'b0; done[3] = 1'b1;
    tick(3);
    compares++;
    if ({g3, v3, i3} !== 3'b000) begin
      fails++; $display("FAIL single_release: got %b want 000", {g3, v3, i3});
    end
    done[3] = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        req[k]  = 4'($urandom);
        done[k] = ($urandom_range(0, (k == 1) ? 11 : 3) == 0);
        tick(k);
        compares++;
        if (obs(k) !== exp_out(k)) begin
          fails++; $display("FAIL random dut%0d cyc%0d: got %b want %b", k, c, obs(k), exp_out(k));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rr_rotation();
    test_drop_request();
    test_back_to_back();
    test_hold_timeout();
    test_fixed_priority();
    test_reset_mid_grant();
    test_single();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
